// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the counter_sched round-robin counter scheduler.
package counter_sched_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} sched_state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 8;
  localparam int MAX_NREQ = 8;
  localparam int IDX_W    = 3;

  function automatic logic [MAX_NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return MAX_NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/counter_sched_if.sv
// Requester + counter bundle; slave side is the scheduler, master side is the environment.
interface counter_sched_if
  import counter_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) ();

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] len;
  logic [W-1:0]      count;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic              cnt_clr;
  logic              cnt_en;

  modport slave (
    input  req, len, count,
    output gnt, done, busy, cnt_clr, cnt_en
  );

  modport master (
    output req, len, count,
    input  gnt, done, busy, cnt_clr, cnt_en
  );

endinterface

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  always_comb begin
    int j;
    j       = 0;
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!o_valid && i_req[j]) begin
        o_valid = 1'b1;
        o_idx   = IW'(j);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_gnt
      assign o_gnt[gi] = o_valid && (o_idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one external up counter among NREQ requesters.
// Optional macro COUNTER_SCHED_ABORT_EN: owner dropping req in LOAD/RUN aborts the window.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic             clk,
  input  logic             rst,
  counter_sched_if.slave   bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_t    r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_owner;
  logic [W-1:0]    r_len_q;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_busy;
  logic            r_clr;

  logic [NREQ-1:0] w_arb_gnt;
  logic [IW-1:0]   w_arb_idx;
  logic            w_arb_valid;
  logic [W-1:0]    w_arb_len;
  logic [IW-1:0]   w_ptr_next;
  logic [NREQ-1:0] w_owner_oh;
  logic            w_at_len;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_arb_len  = bus.len[w_arb_idx*W +: W];
  assign w_ptr_next = (w_arb_idx == IW'(NREQ-1)) ? '0 : w_arb_idx + IW'(1);
  assign w_owner_oh = NREQ'(onehot(IDX_W'(r_owner)));
  assign w_at_len   = (bus.count == r_len_q);

`ifdef COUNTER_SCHED_ABORT_EN
  logic w_owner_req;
  assign w_owner_req = bus.req[r_owner];
  assign bus.cnt_en  = (r_state == RUN) && !w_at_len && w_owner_req;
`else
  // Enable drops combinationally at equality so the counter parks on len_q.
  assign bus.cnt_en  = (r_state == RUN) && !w_at_len;
`endif

  assign bus.gnt     = r_gnt;
  assign bus.done    = r_done;
  assign bus.busy    = r_busy;
  assign bus.cnt_clr = r_clr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_len_q <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_clr  <= 1'b0;
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_arb_valid) begin
            r_state <= LOAD;
            r_owner <= w_arb_idx;
            r_len_q <= w_arb_len;
            r_ptr   <= w_ptr_next;
            r_gnt   <= w_arb_gnt;
            r_busy  <= 1'b1;
            r_clr   <= 1'b1;
          end
        end
        LOAD: begin
`ifdef COUNTER_SCHED_ABORT_EN
          if (!w_owner_req) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end else
`endif
          if (r_len_q == '0) begin
            r_state <= DONE;
            r_done  <= w_owner_oh;
          end else begin
            r_state <= RUN;
          end
        end
        RUN: begin
`ifdef COUNTER_SCHED_ABORT_EN
          if (!w_owner_req) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end else
`endif
          if (w_at_len) begin
            r_state <= DONE;
            r_done  <= w_owner_oh;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Scoreboard bench for counter_sched: expected windows queued at stimulus, checked on done.
module tb_counter_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;

  typedef struct {
    int owner;
    int len;
  } exp_t;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  int   dones_seen;
  int   cyc;
  int   rise_cyc;
  int   en_cnt;
  logic [NREQ-1:0] prev_gnt;
  exp_t sb_q[$];

  counter_sched_if #(.NREQ(NREQ), .W(W)) bus ();

  counter_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the attached counter: clear has priority over enable.
  always_ff @(posedge clk) begin
    if (!rst)             bus.count <= '0;
    else if (bus.cnt_clr) bus.count <= '0;
    else if (bus.cnt_en)  bus.count <= bus.count + 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Monitor: measures each window and pops the scoreboard on done.
  initial begin
    cyc = 0; rise_cyc = 0; en_cnt = 0; dones_seen = 0; prev_gnt = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.gnt != '0 && prev_gnt == '0) begin
        rise_cyc = cyc;
        en_cnt   = 0;
      end
      if (bus.cnt_en) en_cnt++;
      if (bus.done != '0) begin
        if (sb_q.size() == 0) begin
          check_eq("unexp_done", 32'(bus.done), 0);
        end else begin
          exp_t e;
          logic [NREQ-1:0] ev;
          e  = sb_q.pop_front();
          ev = NREQ'(1 << e.owner);
          $display("txn owner=%0d len=%0d done=%b lat=%0d en=%0d count=%0d",
                   e.owner, e.len, bus.done, cyc - rise_cyc, en_cnt, bus.count);
          check_eq("done_vec", 32'(bus.done), 32'(ev));
          check_eq("gnt_at_done", 32'(bus.gnt), 32'(ev));
          check_eq("count_at_done", 32'(bus.count), e.len);
          check_eq("en_cycles", en_cnt, e.len);
          check_eq("done_lat", cyc - rise_cyc, (e.len == 0) ? 1 : e.len + 2);
        end
        dones_seen++;
      end
      prev_gnt = bus.gnt;
    end
  end

  task automatic push_exp(input int owner, input int l);
    exp_t e;
    e.owner = owner;
    e.len   = l;
    sb_q.push_back(e);
  endtask

  task automatic set_len(input int i, input int l);
    bus.len[i*W +: W] = W'(l);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_dones(input int target, input int max_cyc);
    int n = 0;
    while (dones_seen < target && n < max_cyc) begin
      step();
      n++;
    end
    if (dones_seen < target) check_eq("wait_dones", dones_seen, target);
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((sb_q.size() != 0 || bus.busy) && n < max_cyc) begin
      step();
      n++;
    end
    if (n >= max_cyc) begin
      check_eq("drain_q", sb_q.size(), 0);
      check_eq("drain_busy", 32'(bus.busy), 0);
    end
  endtask

  task automatic wait_gnt(input int idx, input int max_cyc);
    int n = 0;
    while (bus.gnt[idx] !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    if (bus.gnt[idx] !== 1'b1) check_eq("wait_gnt", 32'(bus.gnt), 32'(1 << idx));
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  initial begin
    int base;
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b0;
    bus.req = '0;
    bus.len = '0;

    // Reset with all requests pending
    bus.req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    repeat (2) step();
    check_eq("rst_outs", 32'({bus.gnt, bus.done, bus.busy, bus.cnt_clr, bus.cnt_en}), 0);
    for (int i = 0; i < NREQ; i++) push_exp(i, 1);
    base = dones_seen;
    rst = 1'b1;
    step();
    check_eq("rst_first_gnt", 32'(bus.gnt), 32'(4'b0001));
    wait_dones(base + 4, 40);
    bus.req = '0;
    drain(20);

    // Single request
    set_len(2, 5);
    push_exp(2, 5);
    base = dones_seen;
    bus.req = 4'b0100;
    step();
    check_eq("single_gnt", 32'(bus.gnt), 32'(4'b0100));
    check_eq("single_clr", 32'(bus.cnt_clr), 1);
    wait_dones(base + 1, 20);
    bus.req = '0;
    step();
    check_eq("single_busy_fall", 32'(bus.busy), 0);
    drain(20);

    // Round-robin from a fresh pointer
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_len(i, 2);
    push_exp(0, 2); push_exp(1, 2); push_exp(3, 2); push_exp(0, 2);
    base = dones_seen;
    bus.req = 4'b1011;
    wait_dones(base + 4, 60);
    bus.req = '0;
    drain(20);

    // Zero length
    set_len(1, 0);
    push_exp(1, 0);
    base = dones_seen;
    bus.req = 4'b0010;
    wait_dones(base + 1, 20);
    bus.req = '0;
    drain(20);

    // Full scale
    set_len(0, 255);
    push_exp(0, 255);
    base = dones_seen;
    bus.req = 4'b0001;
    wait_dones(base + 1, 300);
    bus.req = '0;
    drain(20);
    repeat (3) step();
    check_eq("full_hold", 32'(bus.count), 255);

    // Drop req[3] at RUN cycle 3 of a 10-tick window
    set_len(3, 10);
    base = dones_seen;
`ifndef COUNTER_SCHED_ABORT_EN
    push_exp(3, 10);
`endif
    bus.req = 4'b1000;
    wait_gnt(3, 10);
    repeat (3) step();
    bus.req = '0;
`ifdef COUNTER_SCHED_ABORT_EN
    #1;
    check_eq("abort_en", 32'(bus.cnt_en), 0);
    step();
    check_eq("abort_gnt", 32'(bus.gnt), 0);
    check_eq("abort_busy", 32'(bus.busy), 0);
    check_eq("abort_count", 32'(bus.count), 2);
    repeat (15) step();
    check_eq("abort_nodone", dones_seen, base);
`else
    wait_dones(base + 1, 30);
    drain(20);
    check_eq("noabort_done", dones_seen, base + 1);
`endif

    // Reset in the middle of a window
    set_len(2, 20);
    base = dones_seen;
    bus.req = 4'b0100;
    wait_gnt(2, 10);
    repeat (5) step();
    rst = 1'b0;
    step();
    check_eq("rst_mid_outs", 32'({bus.gnt, bus.done, bus.busy, bus.cnt_clr, bus.cnt_en}), 0);
    rst = 1'b1;
    bus.req = '0;
    repeat (25) step();
    check_eq("rst_mid_nodone", dones_seen, base);
    check_eq("rst_mid_busy", 32'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
